// File: rtl/latency_timer_pkg.sv
// latency_timer_pkg
// Shared types and default sizing for the latency measurement block.
//   state_e       : measurement FSM states (IDLE, COUNT)
//   LT_WIDTH      : default latency counter / result width (matches the PIO data width)
//   LT_CNT_WIDTH  : default completed-measurement counter width
//   LT_TIMEOUT    : default abandon threshold in clk cycles
package latency_timer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    localparam int unsigned LT_WIDTH     = 16;
    localparam int unsigned LT_CNT_WIDTH = 8;
    localparam int unsigned LT_TIMEOUT   = 32'h0000_FFFF;

endpackage

// File: rtl/latency_edge_sync.sv
// latency_edge_sync
// Single-bit rising-edge detector with an optional two-flop synchronizer in front.
// Build option: LATENCY_TIMER_SYNC_EN adds the synchronizer (2 cycles extra delay).
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   sig_in   in  raw input level
//   edge_out out one-cycle pulse when the (synchronized) level goes 0 -> 1
module latency_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_in,
    output logic edge_out
);

    logic sig_s;
    logic prev_q;
    logic prev_d;

`ifdef LATENCY_TIMER_SYNC_EN
    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = sig_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sig_s = sync_q;
`else
    assign sig_s = sig_in;
`endif

    // The history register always follows the level, so a signal that is
    // already high after a clear never produces a fresh edge.
    always_comb begin
        prev_d = sig_s;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_out = sig_s & ~prev_q;

endmodule

// File: rtl/latency_timer.sv
// latency_timer
// Measures the number of clk cycles between a rising edge on start_in and the
// following rising edge on stop_in. The result feeds a read-only PIO and is
// only ever replaced as a whole word, so software always reads a coherent value.
// Build option: LATENCY_TIMER_SYNC_EN synchronizes both inputs (same delay on
// each path, so the measured latency is unaffected).
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   start_in    in   stimulus; rising edge starts a measurement
//   stop_in     in   response; rising edge ends a measurement
//   clr         in   synchronous clear of measurement, result and status
//   latency     out  last completed latency in cycles
//   busy        out  high while a measurement is in progress
//   done        out  one-cycle pulse when latency is updated
//   overflow    out  sticky; last measurement reached TIMEOUT
//   meas_count  out  number of completed measurements (wraps)
module latency_timer
    import latency_timer_pkg::*;
#(
    parameter int unsigned       WIDTH     = LT_WIDTH,
    parameter logic [WIDTH-1:0]  TIMEOUT   = WIDTH'(LT_TIMEOUT),
    parameter int unsigned       CNT_WIDTH = LT_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_in,
    input  logic                 stop_in,
    input  logic                 clr,
    output logic [WIDTH-1:0]     latency,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] meas_count
);

    logic start_edge;
    logic stop_edge;

    state_e               state_q,      state_d;
    logic [WIDTH-1:0]     count_q,      count_d;
    logic [WIDTH-1:0]     latency_q,    latency_d;
    logic                 busy_q,       busy_d;
    logic                 done_q,       done_d;
    logic                 overflow_q,   overflow_d;
    logic [CNT_WIDTH-1:0] meas_count_q, meas_count_d;

    latency_edge_sync u_start_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .sig_in   (start_in),
        .edge_out (start_edge)
    );

    latency_edge_sync u_stop_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .sig_in   (stop_in),
        .edge_out (stop_edge)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        latency_d    = latency_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        overflow_d   = overflow_q;
        meas_count_d = meas_count_q;

        if (clr) begin
            state_d      = IDLE;
            count_d      = '0;
            latency_d    = '0;
            busy_d       = 1'b0;
            overflow_d   = 1'b0;
            meas_count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A stop edge arriving together with the start edge is dropped.
                    if (start_edge) begin
                        count_d    = WIDTH'(1);
                        busy_d     = 1'b1;
                        overflow_d = 1'b0;
                        state_d    = COUNT;
                    end
                end
                COUNT: begin
                    // count already holds the cycles elapsed since the start edge,
                    // so a stop edge one cycle later reports 1.
                    if (stop_edge) begin
                        latency_d    = count_q;
                        done_d       = 1'b1;
                        meas_count_d = meas_count_q + CNT_WIDTH'(1);
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end else if (count_q == TIMEOUT) begin
                        latency_d    = TIMEOUT;
                        overflow_d   = 1'b1;
                        done_d       = 1'b1;
                        meas_count_d = meas_count_q + CNT_WIDTH'(1);
                        busy_d       = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            latency_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            meas_count_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            latency_q    <= latency_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            meas_count_q <= meas_count_d;
        end
    end

    assign latency    = latency_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign meas_count = meas_count_q;

endmodule

// File: doc/latency_timer.md
Name: latency_timer

Overview:
Measures response latency in clk cycles between a stimulus edge (start_in) and a response edge (stop_in). The result drives the 16-bit in_port of the downstream read-only PIO slave, which software polls. It sits directly upstream of that PIO in the lab-2 latency measurement path. It also provides busy/done/overflow status bits and a measurement counter for a second PIO.

Parameters:
WIDTH, 16, width of latency counter and result; must match downstream PIO data width
TIMEOUT, 16'hFFFF, cycle count at which a pending measurement is abandoned; 1..2^WIDTH-1
CNT_WIDTH, 8, width of completed-measurement counter

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start_in  in  1  stimulus signal; rising edge starts a measurement
stop_in  in  1  response signal; rising edge ends a measurement
clr  in  1  synchronous clear; aborts measurement, clears result/status
latency  out  WIDTH  last completed latency in cycles; feeds PIO in_port
busy  out  1  high while measuring
done  out  1  one-cycle pulse when latency updates
overflow  out  1  sticky; last measurement hit TIMEOUT
meas_count  out  CNT_WIDTH  completed measurements, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: clk; reset reset_n, asynchronous, active-low. All outputs 0, state IDLE, internal count 0, edge-detect registers 0.
- Edge detect: start_edge/stop_edge = signal high this cycle and low the previous cycle (after optional sync). Exactly one detect register per input.
- States: IDLE, COUNT.
- IDLE:
  - start_edge: count<=1, busy<=1, overflow<=0, go COUNT.
  - stop_edge: ignored.
  - start_edge and stop_edge in the same cycle: start wins, stop is discarded.
- COUNT:
  - stop_edge: latency<=count, done pulse for 1 cycle, meas_count+1, busy<=0, go IDLE.
  - Else if count==TIMEOUT: latency<=TIMEOUT, overflow<=1, done pulse, meas_count+1, busy<=0, go IDLE.
  - Else count<=count+1.
  - start_edge while in COUNT: ignored, no restart.
- Latency definition: stop edge detected N cycles after start edge is detected gives latency=N. Minimum reportable value is 1.
- latency holds its value until the next done or clr. It is never partially updated, so a PIO read is always coherent.
- clr: highest priority below reset. Go IDLE; latency, count, meas_count, overflow, busy cleared; done=0 that cycle. Edge-detect registers keep tracking inputs, so an already-high level does not re-trigger.
- meas_count wraps from all-ones to 0 without a flag.
- Counter arithmetic is unsigned WIDTH-bit. TIMEOUT guarantees no wrap.

Optional Feature:
LATENCY_TIMER_SYNC_EN
- Defined: start_in and stop_in each pass through a 2-flop synchronizer (reset to 0) before edge detect. Both paths have identical delay, so reported latency is unchanged, but response to pins is 2 cycles later (busy rises 3 cycles after start_in rises).
- Undefined: inputs are treated as synchronous to clk. Edge detect operates directly on them, and busy rises 1 cycle after start_in rises.

Decomposition:
- Package latency_timer_pkg: state enum (IDLE, COUNT), default WIDTH/CNT_WIDTH/TIMEOUT constants.
- One sub-module, latency_edge_sync (1-bit): optional 2-flop sync plus rising-edge detect. Instantiated twice, for start and stop.
- FSM, counter and result registers live in the top.

Test Plan:
- Reset: hold reset_n low with inputs toggling -> all outputs 0. Release -> latency=0, busy=0.
- Basic: start rise, stop rise 25 cycles after start is detected -> latency=25, done 1 cycle, meas_count=1, overflow=0.
- Timeout: TIMEOUT=100, start and no stop -> after 100 cycles latency=100, overflow=1, busy=0. A later stop is ignored. A new start clears overflow.
- Simultaneous/ignored edges: start and stop rise in the same IDLE cycle -> measurement begins. Second start at cycle 10 then stop at 40 -> latency=40. Stop in IDLE -> no change.
- clr mid-measurement: clr at cycle 7 -> busy=0, latency=0, meas_count=0, no done. Next start/stop 5 cycles apart -> latency=5.
- Wrap/sync: 257 measurements -> meas_count=1. With LATENCY_TIMER_SYNC_EN defined, 25-cycle stimulus -> latency=25 and done 2 cycles later than without the macro.
